// File: rtl/picorv32_ddr_bridge.sv
// PicoRV32 native bus to single-beat DDR model bridge, one outstanding transaction.
// Optional response watchdog in WAIT enabled by defining PICORV32_DDR_TIMEOUT_EN.
module picorv32_ddr_bridge #(
    parameter logic [31:0] DDR_BASE  = 32'h0000_0000,
    parameter int          DDR_WORDS = 16384,
    parameter int          DDR_AW    = 14,
    parameter int          TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ddr_rd_req,
    output logic              ddr_wr_req,
    output logic [DDR_AW-1:0] ddr_addr,
    output logic [31:0]       ddr_wr_data,
    output logic [3:0]        ddr_wr_strb,
    input  logic              ddr_rd_valid,
    input  logic [31:0]       ddr_rd_data,
    input  logic              ddr_wr_ack,
    output logic              bus_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, LOCAL} state_t;
    state_t state;

    logic [32:0]       addr_x;
    logic [32:0]       win_lo;
    logic [32:0]       win_hi;
    logic              in_win;
    logic [DDR_AW-1:0] word_off;
    logic              is_rd;
    logic              resp_hit;

    // 33-bit compare so a window ending at 4 GiB cannot wrap to zero
    assign addr_x   = {1'b0, mem_addr};
    assign win_lo   = {1'b0, DDR_BASE};
    assign win_hi   = win_lo + (33'(DDR_WORDS) << 2);
    assign in_win   = (addr_x >= win_lo) && (addr_x < win_hi);
    assign word_off = mem_addr[DDR_AW+1:2] - DDR_BASE[DDR_AW+1:2];
    assign is_rd    = (ddr_wr_strb == 4'b0000);

    // A response coincident with our own request pulse is treated as not yet arrived
    assign resp_hit = !(ddr_rd_req || ddr_wr_req) &&
                      (is_rd ? ddr_rd_valid : ddr_wr_ack);

`ifdef PICORV32_DDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_ready   <= 1'b0;
            mem_rdata   <= 32'h0;
            ddr_rd_req  <= 1'b0;
            ddr_wr_req  <= 1'b0;
            ddr_addr    <= '0;
            ddr_wr_data <= 32'h0;
            ddr_wr_strb <= 4'b0000;
            bus_err     <= 1'b0;
`ifdef PICORV32_DDR_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            mem_ready  <= 1'b0;
            ddr_rd_req <= 1'b0;
            ddr_wr_req <= 1'b0;
            case (state)
                IDLE: begin
                    // mem_ready still high here after LOCAL: the CPU has not dropped valid yet
                    if (mem_valid && !mem_ready) begin
                        ddr_addr    <= word_off;
                        ddr_wr_data <= mem_wdata;
                        ddr_wr_strb <= mem_wstrb;
                        state       <= in_win ? ISSUE : LOCAL;
                    end
                end
                ISSUE: begin
                    ddr_rd_req <= is_rd;
                    ddr_wr_req <= !is_rd;
`ifdef PICORV32_DDR_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: begin
                    if (resp_hit) begin
                        mem_rdata <= is_rd ? ddr_rd_data : 32'h0;
                        mem_ready <= 1'b1;
                        state     <= RESP;
                    end
`ifdef PICORV32_DDR_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                        mem_rdata <= 32'hDEAD_BEEF;
                        mem_ready <= 1'b1;
                        bus_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                LOCAL: begin
                    mem_ready <= 1'b1;
                    mem_rdata <= 32'h0;
                    bus_err   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
